mm_job_sched: RTL and testbench
===============================

Name: mm_job_sched

Overview:
- Job scheduler in front of the matrix-multiply controller.
- Accepts job descriptors (mode, tag) over a valid/ready interface and buffers them in a small FIFO.
- Issues one start pulse per job to the matrix controller, then tracks its tile-done and matrix-done pulses. A watchdog guards against a stalled datapath.
- Returns one completion record (tag, tile count, error code) per job over a valid/ready interface.

Parameters:
- DEPTH, 4, job FIFO entries (power of 2, min 2)
- TW, 8, job tag width
- TILES, 1024, expected tile_done pulses per job (32 row x 32 col tiles)
- WDOG, 256, max cycles between consecutive done pulses while running (one tile = 64 cycles)

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, synchronous, active-low
- i_job_valid  input  1  job descriptor valid
- o_job_ready  output  1  FIFO can accept (not full, not halted)
- i_job_mode  input  2  0 INT8, 1 INT4, 2 INT4_VSQ, 3 illegal
- i_job_tag  input  TW  job identifier
- o_mm_start  output  1  one-cycle start pulse to matrix controller
- o_mm_mode  output  2  mode, valid in start cycle
- i_tile_done  input  1  tile done pulse
- i_mtrx_done  input  1  matrix done pulse
- o_cpl_valid  output  1  completion valid
- i_cpl_ready  input  1  completion accepted
- o_cpl_tag  output  TW  tag of completed job
- o_cpl_tiles  output  11  tile_done pulses counted for the job
- o_cpl_err  output  2  0 ok, 1 illegal mode, 2 tile count mismatch, 3 watchdog
- o_busy  output  1  state != IDLE or FIFO non-empty
- o_halted  output  1  sticky after watchdog, cleared by reset only

Behaviour:
- Interface: one clock i_clk; synchronous active-low reset i_rst_n sampled on the rising edge.
- Reset values:
  - o_mm_start=0, o_mm_mode=0, o_cpl_valid=0, o_cpl_tag=0, o_cpl_tiles=0, o_cpl_err=0, o_halted=0.
  - FIFO empty, state IDLE, counters 0.
  - Reset mid-job drops all queued and in-flight jobs; no completion is produced for them.
- FIFO:
  - Push when i_job_valid && o_job_ready.
  - o_job_ready = !full && !o_halted.
  - Pop only in IDLE when non-empty and no completion pending.
  - Push and pop in the same cycle are allowed at any occupancy, including full; a push is still refused while full.
- States:
  - IDLE: FIFO non-empty and o_cpl_valid==0 -> pop the head. If the head mode==3, go to CPL with err=1 and tiles=0; no start is issued. Otherwise latch mode and tag and go to START.
  - START: o_mm_start=1 for exactly this cycle with o_mm_mode=latched mode; clear the tile counter and the watchdog; go to RUN.
  - RUN:
    - Count i_tile_done pulses; the counter saturates at 2047.
    - The watchdog increments every cycle and is cleared on any i_tile_done or i_mtrx_done.
    - On i_mtrx_done go to CPL. Err=2 if count != TILES, else 0. A tile_done asserted in the same cycle as mtrx_done is counted.
    - If the watchdog reaches WDOG-1 with no pulse -> CPL with err=3 and set o_halted.
  - CPL: register a completion record and assert o_cpl_valid one cycle after entry. Hold all completion fields stable until i_cpl_ready. On the handshake, drop o_cpl_valid the next cycle and go to HALT if o_halted, else IDLE.
  - HALT: absorbing; no pops, no starts, o_job_ready=0. Exit only via reset.
- Pulses on i_tile_done or i_mtrx_done outside RUN are ignored.
- Back-to-back jobs:
  - With i_cpl_ready held high, the gap from i_mtrx_done to the next o_mm_start is 4 cycles: CPL, valid, IDLE pop, START.
  - The controller sees at most one start per job.
- Latency: a push into an empty FIFO in IDLE produces o_mm_start 2 cycles after the push cycle.

Test Plan:
- TILES=4: push job (mode=1, tag=0x11); drive 4 tile_done pulses 64 cycles apart, the last coincident with mtrx_done -> exactly one o_mm_start with o_mm_mode=1; completion tag=0x11, tiles=4, err=0.
- Push 5 jobs back-to-back with DEPTH=4 while the first is running -> o_job_ready low on the 5th attempt until a pop. All completions return in push order with matching tags.
- Push mode=3, tag=0x22 -> no o_mm_start; completion err=1, tiles=0, returned within 3 cycles of the pop.
- TILES=4: drive only 3 tile_done before mtrx_done -> completion tiles=3, err=2; the next job still starts.
- WDOG=16: start a job and drive no pulses -> after 16 cycles a completion with err=3; o_halted=1, o_job_ready=0. Later pulses and pushes are ignored until reset.
- Hold i_cpl_ready=0 for 20 cycles with 2 jobs queued -> completion fields stable and no second o_mm_start. Assert reset mid-RUN -> all outputs return to reset values and the FIFO is empty.

Source files
------------

// File: rtl/mm_job_sched.sv
// Job scheduler for the matrix-multiply controller.
// Queues (mode, tag) descriptors, issues one start per job, supervises its done pulses and returns a completion record.
module mm_job_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = 8,
    parameter int unsigned TILES = 1024,
    parameter int unsigned WDOG  = 256
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_job_valid,
    output logic          o_job_ready,
    input  logic [1:0]    i_job_mode,
    input  logic [TW-1:0] i_job_tag,
    output logic          o_mm_start,
    output logic [1:0]    o_mm_mode,
    input  logic          i_tile_done,
    input  logic          i_mtrx_done,
    output logic          o_cpl_valid,
    input  logic          i_cpl_ready,
    output logic [TW-1:0] o_cpl_tag,
    output logic [10:0]   o_cpl_tiles,
    output logic [1:0]    o_cpl_err,
    output logic          o_busy,
    output logic          o_halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 11;
    localparam int unsigned WW = (WDOG > 2) ? $clog2(WDOG) : 1;
    localparam int unsigned EW = TW + 2;

    localparam logic [1:0] MODE_ILL  = 2'd3;
    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_MODE  = 2'd1;
    localparam logic [1:0] ERR_TILES = 2'd2;
    localparam logic [1:0] ERR_WDOG  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_CPL   = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [EW-1:0]   fifo_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [1:0]      mode_q, mode_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [1:0]      err_q, err_d;
    logic            halted_q, halted_d;
    logic            start_q, start_d;
    logic            cpl_valid_q, cpl_valid_d;
    logic [TW-1:0]   cpl_tag_q, cpl_tag_d;
    logic [CW-1:0]   cpl_tiles_q, cpl_tiles_d;
    logic [1:0]      cpl_err_q, cpl_err_d;

    logic            fifo_full, fifo_empty, push, pop;
    logic [EW-1:0]   head;

    // Extra pointer bit distinguishes full from empty at equal indices.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_q[rd_ptr_q[AW-1:0]];

    assign o_job_ready = !fifo_full && !halted_q;
    assign push        = i_job_valid && o_job_ready;

    assign o_mm_start  = start_q;
    assign o_mm_mode   = mode_q;
    assign o_cpl_valid = cpl_valid_q;
    assign o_cpl_tag   = cpl_tag_q;
    assign o_cpl_tiles = cpl_tiles_q;
    assign o_cpl_err   = cpl_err_q;
    assign o_halted    = halted_q;
    assign o_busy      = (state_q != S_IDLE) || !fifo_empty;

    // Next-state and job bookkeeping.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        halted_d    = halted_q;
        start_d     = 1'b0;
        cpl_valid_d = cpl_valid_q;
        cpl_tag_d   = cpl_tag_q;
        cpl_tiles_d = cpl_tiles_q;
        cpl_err_d   = cpl_err_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !cpl_valid_q) begin
                    pop   = 1'b1;
                    tag_d = head[TW-1:0];
                    if (head[EW-1:TW] == MODE_ILL) begin
                        err_d   = ERR_MODE;
                        cnt_d   = '0;
                        state_d = S_CPL;
                    end else begin
                        mode_d  = head[EW-1:TW];
                        start_d = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                wdog_d  = '0;
                err_d   = ERR_OK;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (i_tile_done && (cnt_q != {CW{1'b1}})) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (i_tile_done || i_mtrx_done) begin
                    wdog_d = '0;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
                // A tile_done coincident with mtrx_done is already in cnt_d.
                if (i_mtrx_done) begin
                    err_d   = (cnt_d != CW'(TILES)) ? ERR_TILES : ERR_OK;
                    state_d = S_CPL;
                end else if (!i_tile_done && (wdog_q == WW'(WDOG - 1))) begin
                    err_d    = ERR_WDOG;
                    halted_d = 1'b1;
                    state_d  = S_CPL;
                end
            end
            S_CPL: begin
                if (!cpl_valid_q) begin
                    cpl_valid_d = 1'b1;
                    cpl_tag_d   = tag_q;
                    cpl_tiles_d = cnt_q;
                    cpl_err_d   = err_q;
                end else if (i_cpl_ready) begin
                    cpl_valid_d = 1'b0;
                    state_d     = halted_q ? S_HALT : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Descriptor storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= {i_job_mode, i_job_tag};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mode_q      <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            wdog_q      <= '0;
            err_q       <= ERR_OK;
            halted_q    <= 1'b0;
            start_q     <= 1'b0;
            cpl_valid_q <= 1'b0;
            cpl_tag_q   <= '0;
            cpl_tiles_q <= '0;
            cpl_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
            mode_q      <= mode_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
            halted_q    <= halted_d;
            start_q     <= start_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_tag_q   <= cpl_tag_d;
            cpl_tiles_q <= cpl_tiles_d;
            cpl_err_q   <= cpl_err_d;
        end
    end

endmodule

// File: tb/tb_mm_job_sched.sv
// Scoreboard bench for mm_job_sched (TILES=4, WDOG=16, DEPTH=4).
// Stimulus queues expected starts/completions; a negedge monitor pops and compares them.
module tb_mm_job_sched;

    localparam int unsigned TW = 8;

    logic          clk = 1'b0;
    logic          rst_n, job_valid, job_ready, mm_start, tile_done, mtrx_done;
    logic          cpl_valid, cpl_ready, busy, halted;
    logic [1:0]    job_mode, mm_mode, cpl_err;
    logic [TW-1:0] job_tag, cpl_tag;
    logic [10:0]   cpl_tiles;

    always #5 clk = ~clk;

    mm_job_sched #(.DEPTH(4), .TW(TW), .TILES(4), .WDOG(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_job_valid (job_valid),
        .o_job_ready (job_ready),
        .i_job_mode  (job_mode),
        .i_job_tag   (job_tag),
        .o_mm_start  (mm_start),
        .o_mm_mode   (mm_mode),
        .i_tile_done (tile_done),
        .i_mtrx_done (mtrx_done),
        .o_cpl_valid (cpl_valid),
        .i_cpl_ready (cpl_ready),
        .o_cpl_tag   (cpl_tag),
        .o_cpl_tiles (cpl_tiles),
        .o_cpl_err   (cpl_err),
        .o_busy      (busy),
        .o_halted    (halted)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [10:0]   tiles;
        logic [1:0]    err;
    } cpl_t;

    cpl_t       exp_cpl[$];
    logic [1:0] exp_start[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_starts = 0;
    int         cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endfunction

    // Monitor: every start and every presented completion is matched against the queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mm_start === 1'b1) begin
                n_starts++;
                check("start_expected", 32'(exp_start.size() > 0), 1);
                if (exp_start.size() > 0) check("start_mode", 32'(mm_mode), 32'(exp_start.pop_front()));
            end
            if (cpl_valid === 1'b1) begin
                check("cpl_expected", 32'(exp_cpl.size() > 0), 1);
                if (exp_cpl.size() > 0) begin
                    check("cpl_tag",   32'(cpl_tag),   32'(exp_cpl[0].tag));
                    check("cpl_tiles", 32'(cpl_tiles), 32'(exp_cpl[0].tiles));
                    check("cpl_err",   32'(cpl_err),   32'(exp_cpl[0].err));
                    if (cpl_ready) void'(exp_cpl.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] m, input logic [TW-1:0] t, input logic [10:0] tl,
                        input logic [1:0] e, output int p0);
        int   n = 0;
        cpl_t c;
        while (!job_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_ready", 32'(job_ready), 1);
        job_valid = 1'b1;
        job_mode  = m;
        job_tag   = t;
        p0        = cyc;
        if (m != 2'd3) exp_start.push_back(m);
        c.tag   = t;
        c.tiles = tl;
        c.err   = e;
        exp_cpl.push_back(c);
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_start(output int c);
        int n = 0;
        while (!mm_start && n < 60) begin
            tick();
            n++;
        end
        check("start_seen", 32'(mm_start), 1);
        c = cyc;
    endtask

    // n tile pulses six idle cycles apart; the last one coincides with mtrx_done.
    task automatic run_job(input int n, output int c0);
        c0 = 0;
        for (int i = 0; i < n; i++) begin
            repeat (6) tick();
            tile_done = 1'b1;
            mtrx_done = (i == n - 1);
            if (i == n - 1) c0 = cyc;
            tick();
            tile_done = 1'b0;
            mtrx_done = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || cpl_valid) && n < 100) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy | cpl_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mm_start"},  32'(mm_start),  0);
        check({tag, "_mm_mode"},   32'(mm_mode),   0);
        check({tag, "_cpl_valid"}, 32'(cpl_valid), 0);
        check({tag, "_cpl_tag"},   32'(cpl_tag),   0);
        check({tag, "_cpl_tiles"}, 32'(cpl_tiles), 0);
        check({tag, "_cpl_err"},   32'(cpl_err),   0);
        check({tag, "_halted"},    32'(halted),    0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_job_ready"}, 32'(job_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t required < 100000", $time);
        $fatal(1);
    end

    initial begin
        int p, c, c0, c1, v, h, ns, n;
        rst_n = 1'b0; job_valid = 1'b0; job_mode = '0; job_tag = '0;
        tile_done = 1'b0; mtrx_done = 1'b0; cpl_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Single INT4 job: start two cycles after push, four tiles, clean completion.
        push(2'd1, 8'h11, 11'd4, 2'd0, p);
        wait_start(c);
        check("start_latency", 32'(c - p), 2);
        run_job(4, c0);
        wait_idle();
        check("t1_cpl_drained", 32'(exp_cpl.size()), 0);
        check("t1_start_count", 32'(n_starts), 1);

        // Fill the FIFO behind a running job, then drain in order; C is short one tile.
        push(2'd0, 8'hA0, 11'd4, 2'd0, p);
        wait_start(c);
        push(2'd2, 8'hB1, 11'd4, 2'd0, p);
        push(2'd1, 8'hC2, 11'd3, 2'd2, p);
        push(2'd0, 8'hD3, 11'd4, 2'd0, p);
        push(2'd2, 8'hE4, 11'd4, 2'd0, p);
        check("full_ready_low", 32'(job_ready), 0);
        job_valid = 1'b1; job_mode = 2'd1; job_tag = 8'hF5;
        repeat (2) begin
            tick();
            check("full_refuse", 32'(job_ready), 0);
        end
        job_valid = 1'b0;
        run_job(4, c0);
        wait_start(c1);
        // mtrx_done cycle to next start: CPL, valid, pop, START.
        check("b2b_gap", 32'(c1 - c0), 4);
        push(2'd1, 8'hF5, 11'd4, 2'd0, p);
        run_job(4, c0);
        wait_start(c);
        run_job(3, c0);
        wait_start(c);
        run_job(4, c0);
        wait_start(c);
        run_job(4, c0);
        wait_start(c);
        run_job(4, c0);
        wait_idle();
        check("t2_cpl_drained", 32'(exp_cpl.size()), 0);
        check("t2_start_count", 32'(n_starts), 7);

        // Illegal mode: no start, error completion shortly after the pop.
        push(2'd3, 8'h22, 11'd0, 2'd1, p);
        n = 0;
        while (!cpl_valid && n < 20) begin
            tick();
            n++;
        end
        v = cyc;
        check("illegal_cpl_seen", 32'(cpl_valid), 1);
        check("illegal_cpl_latency", 32'((v - p) <= 4), 1);
        wait_idle();
        check("t3_cpl_drained", 32'(exp_cpl.size()), 0);
        check("t3_start_count", 32'(n_starts), 7);

        // Back-pressured completion with two jobs queued, then reset mid-run.
        cpl_ready = 1'b0;
        push(2'd2, 8'h33, 11'd4, 2'd0, p);
        wait_start(c);
        push(2'd0, 8'h44, 11'd4, 2'd0, p);
        push(2'd1, 8'h55, 11'd4, 2'd0, p);
        run_job(4, c0);
        ns = n_starts;
        repeat (20) tick();
        check("stall_valid_held", 32'(cpl_valid), 1);
        check("stall_no_start", 32'(n_starts), 32'(ns));
        cpl_ready = 1'b1;
        wait_start(c);
        repeat (3) tick();
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        tick();
        rst_n = 1'b0;
        exp_cpl.delete();
        exp_start.delete();
        tick();
        check_reset_outputs("midrun");
        rst_n = 1'b1;
        ns = n_starts;
        repeat (6) tick();
        check("post_reset_idle", 32'(busy | cpl_valid), 0);
        check("post_reset_no_start", 32'(n_starts), 32'(ns));

        // Watchdog: no pulses after start -> err 3 and sticky halt.
        cpl_ready = 1'b0;
        push(2'd1, 8'h66, 11'd0, 2'd3, p);
        wait_start(c);
        n = 0;
        while (!halted && n < 40) begin
            tick();
            n++;
        end
        h = cyc;
        check("wdog_halted", 32'(halted), 1);
        // Sixteen silent RUN cycles follow the START cycle.
        check("wdog_latency", 32'(h - c), 17);
        check("halt_ready_low", 32'(job_ready), 0);
        tick();
        check("wdog_cpl_valid", 32'(cpl_valid), 1);
        cpl_ready = 1'b1;
        tick();
        tick();
        check("wdog_cpl_dropped", 32'(cpl_valid), 0);
        check("wdog_cpl_drained", 32'(exp_cpl.size()), 0);
        ns = n_starts;
        job_valid = 1'b1; job_mode = 2'd0; job_tag = 8'h77;
        tile_done = 1'b1; mtrx_done = 1'b1;
        repeat (4) begin
            tick();
            check("halt_ready", 32'(job_ready), 0);
        end
        job_valid = 1'b0; tile_done = 1'b0; mtrx_done = 1'b0;
        repeat (4) tick();
        check("halt_sticky", 32'(halted), 1);
        check("halt_busy", 32'(busy), 1);
        check("halt_no_cpl", 32'(cpl_valid), 0);
        check("halt_no_start", 32'(n_starts), 32'(ns));
        rst_n = 1'b0;
        tick();
        check_reset_outputs("halt_rst");
        rst_n = 1'b1;
        tick();
        check("after_halt_ready", 32'(job_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
